// File: rtl/osfm_issue_ctrl.sv
// Issue/collect controller for the OSF approximate multiplier: derives the shift hint, tracks credits and in-flight
// products, and returns products in order from a small FIFO. Define OSFM_SHIFT_STATS_EN to add accept statistics.
module osfm_issue_ctrl #(
    parameter int unsigned BITWIDTH      = 8,
    parameter int unsigned SHIFTDISTANCE = 2,
    parameter int unsigned MULT_LAT      = 2,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BITWIDTH-1:0]     in_a,
    input  logic [BITWIDTH-1:0]     in_b,
    output logic [BITWIDTH-1:0]     mult_a,
    output logic [BITWIDTH-1:0]     mult_b,
    output logic [1:0]              mult_shift_possible,
    input  logic [2*BITWIDTH-1:0]   mult_r,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*BITWIDTH-1:0]   out_r,
    output logic [1:0]              out_shift,
    input  logic                    flush,
    output logic                    flush_done
`ifdef OSFM_SHIFT_STATS_EN
    ,
    output logic [31:0]             stat_total,
    output logic [31:0]             stat_shifted
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = 2 * BITWIDTH;

    typedef enum logic [1:0] {IDLE, FLUSH_WAIT, FLUSH_CLR} state_t;
    typedef struct packed {
        logic [RW-1:0] r;
        logic [1:0]    s;
    } entry_t;

    state_t              state_q, state_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [CW-1:0]       infl_q, infl_n;
    logic [CW:0]         credit_sum;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [MULT_LAT-1:0] iss_q;
    logic [1:0]          hint_q [MULT_LAT];
    entry_t              fifo_q [DEPTH];
    logic [1:0]          hint_c;
    logic                accept, capture, pop, clear;

    assign hint_c = {in_b[SHIFTDISTANCE-1:0] == '0, in_a[SHIFTDISTANCE-1:0] == '0};

    // Next state plus occupancy bookkeeping; the credit sum looks one cycle ahead for the registered in_ready.
    always_comb begin
        state_n = state_q;
        clear   = 1'b0;
        accept  = in_valid && in_ready;
        capture = iss_q[MULT_LAT-1];
        pop     = out_valid && out_ready;
        case (state_q)
            IDLE:       if (flush) state_n = FLUSH_WAIT;
            FLUSH_WAIT: if (infl_q == '0) begin
                            state_n = FLUSH_CLR;
                            clear   = 1'b1;
                        end
            FLUSH_CLR:  state_n = IDLE;
            default:    state_n = IDLE;
        endcase
        cnt_n = cnt_q;
        if (clear)                cnt_n = '0;
        else if (capture && !pop) cnt_n = cnt_q + CW'(1);
        else if (!capture && pop) cnt_n = cnt_q - CW'(1);
        infl_n = infl_q;
        if (accept && !capture)      infl_n = infl_q + CW'(1);
        else if (!accept && capture) infl_n = infl_q - CW'(1);
        credit_sum = (CW+1)'(cnt_n) + (CW+1)'(infl_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            infl_q              <= '0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            iss_q               <= '0;
            in_ready            <= 1'b0;
            out_valid           <= 1'b0;
            flush_done          <= 1'b0;
            mult_a              <= '0;
            mult_b              <= '0;
            mult_shift_possible <= '0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            infl_q     <= infl_n;
            iss_q      <= (iss_q << 1) | MULT_LAT'(accept);
            in_ready   <= (state_n == IDLE) && (credit_sum < (CW+1)'(DEPTH));
            out_valid  <= (cnt_n != '0);
            flush_done <= (state_n == FLUSH_CLR);
            if (accept) begin
                mult_a              <= in_a;
                mult_b              <= in_b;
                mult_shift_possible <= hint_c;
            end
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (capture) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Payload storage needs no reset: entries are only observed behind out_valid / iss_q.
    always_ff @(posedge clk) begin
        hint_q[0] <= hint_c;
        for (int unsigned i = 1; i < MULT_LAT; i++) hint_q[i] <= hint_q[i-1];
        if (capture) fifo_q[wr_ptr_q] <= '{r: mult_r, s: hint_q[MULT_LAT-1]};
    end

    always_comb begin
        out_r     = '0;
        out_shift = '0;
        if (out_valid) begin
            out_r     = fifo_q[rd_ptr_q].r;
            out_shift = fifo_q[rd_ptr_q].s;
        end
    end

`ifdef OSFM_SHIFT_STATS_EN
    // Saturating counters, untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_total   <= '0;
            stat_shifted <= '0;
        end else if (accept) begin
            if (stat_total != '1) stat_total <= stat_total + 32'd1;
            if ((hint_c != 2'b00) && (stat_shifted != '1)) stat_shifted <= stat_shifted + 32'd1;
        end
    end
`endif

endmodule
